// File: rtl/ascon_rng_ctrl.sv
// ascon_rng_ctrl: sequencing controller running an external ASCON permutation
// as a sponge DRBG. It absorbs a 128-bit seed, fires the permutation, squeezes
// 64-bit words (x0) over a valid/ready stream and forces a reseed after
// RESEED_INTERVAL words.
// Optional feature macro: ASCON_RNG_HEALTH_EN (repetition health test).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. valid/data are held stable until that edge, and valid never
// depends combinationally on ready.
module ascon_rng_ctrl #(
  parameter int unsigned RESEED_INTERVAL = 1024,
  parameter int unsigned TIMEOUT_CYCLES  = 32,
  parameter logic [63:0] IV              = 64'h80400C0600000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic [127:0] seed_data,
  output logic         rnd_valid,
  input  logic         rnd_ready,
  output logic [63:0]  rnd_data,
  output logic         perm_start,
  output logic [319:0] perm_state_in,
  input  logic [319:0] perm_state_out,
  input  logic         perm_done,
  output logic         reseed_req,
  output logic         busy,
  output logic         error,
  output logic [2:0]   dbg_state
);

  localparam int CW = $clog2(RESEED_INTERVAL + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESEED_INTERVAL);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT      = 3'd2,
    S_OUT       = 3'd3,
    S_NEED_SEED = 3'd4,
    S_ERR       = 3'd5
  } state_e;

  state_e          r_fsm;
  state_e          w_fsm_nxt;
  logic [319:0]    r_state;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tmo;
  logic            r_armed;   // done has been seen low since the start pulse
  logic            r_live;    // keeps seed_ready low while reset is applied
  logic            w_seed_hs;
  logic            w_rnd_hs;
  logic            w_done_q;
  logic            w_repeat;
  logic [CW-1:0]   w_cnt_inc;

  assign w_seed_hs = seed_valid & seed_ready;
  assign w_rnd_hs  = rnd_valid & rnd_ready;
  assign w_cnt_inc = r_cnt + 1'b1;
  // A done level is only trusted after the first WAIT cycle and after it has
  // dropped once, so a level left over from the previous run is never taken.
  assign w_done_q  = (r_fsm == S_WAIT) & perm_done & r_armed & (r_tmo != '0);

`ifdef ASCON_RNG_HEALTH_EN
  logic [63:0] r_last;
  logic        r_last_vld;

  assign w_repeat = r_last_vld & (perm_state_out[319:256] == r_last);

  // Remember the last emitted word; any seed absorb invalidates it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (w_seed_hs) begin
      r_last_vld <= 1'b0;
    end else if (w_rnd_hs) begin
      r_last     <= r_state[319:256];
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next-state logic
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:      if (w_seed_hs) w_fsm_nxt = S_START;
      S_START:     w_fsm_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_q)              w_fsm_nxt = w_repeat ? S_ERR : S_OUT;
        else if (r_tmo == TMO_LAST) w_fsm_nxt = S_ERR;
      end
      S_OUT: begin
        if (w_rnd_hs) w_fsm_nxt = (w_cnt_inc == CNT_LAST) ? S_NEED_SEED : S_START;
      end
      S_NEED_SEED: if (w_seed_hs) w_fsm_nxt = S_START;
      S_ERR:       w_fsm_nxt = S_ERR;
      default:     w_fsm_nxt = S_ERR;
    endcase
  end

  // Output decode from the current state only
  always_comb begin
    seed_ready = 1'b0;
    rnd_valid  = 1'b0;
    perm_start = 1'b0;
    reseed_req = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    case (r_fsm)
      S_IDLE:      seed_ready = r_live;
      S_START: begin
        perm_start = 1'b1;
        busy       = 1'b1;
      end
      S_WAIT:      busy = 1'b1;
      S_OUT:       rnd_valid = 1'b1;
      S_NEED_SEED: begin
        reseed_req = 1'b1;
        seed_ready = 1'b1;
      end
      S_ERR:       error = 1'b1;
      default:     error = 1'b1;
    endcase
  end

  assign rnd_data      = rnd_valid ? r_state[319:256] : 64'h0;
  assign perm_state_in = r_state;
  assign dbg_state     = r_fsm;

  // Sponge state, word counter and permutation timeout bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_armed <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_fsm)
        S_IDLE: if (w_seed_hs) r_state <= {IV, seed_data, 128'h0};
        S_START: begin
          r_tmo   <= '0;
          r_armed <= 1'b0;
        end
        S_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (!perm_done) r_armed <= 1'b1;
          if (w_done_q)   r_state <= perm_state_out;
        end
        S_OUT: if (w_rnd_hs) r_cnt <= (w_cnt_inc == CNT_LAST) ? '0 : w_cnt_inc;
        S_NEED_SEED: if (w_seed_hs) r_state[255:128] <= r_state[255:128] ^ seed_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_rng_ctrl.sv
// Directed testbench for ascon_rng_ctrl with a behavioural permutation stand-in.
module tb_ascon_rng_ctrl;

  localparam int          RI  = 4;
  localparam int          TMO = 32;
  localparam int          LAT = 13;
  localparam logic [63:0] IV  = 64'h80400C0600000000;
  localparam logic [63:0] CONST_X0 = 64'hC0FFEE0012345678;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         seed_valid = 1'b0;
  logic         seed_ready;
  logic [127:0] seed_data = '0;
  logic         rnd_valid;
  logic         rnd_ready = 1'b0;
  logic [63:0]  rnd_data;
  logic         perm_start;
  logic [319:0] perm_state_in;
  logic [319:0] perm_state_out = '0;
  logic         perm_done = 1'b0;
  logic         reseed_req;
  logic         busy;
  logic         error;
  logic [2:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [319:0] exp_state;

  ascon_rng_ctrl #(.RESEED_INTERVAL(RI), .TIMEOUT_CYCLES(TMO), .IV(IV)) dut (
    .clk(clk), .rst_n(rst_n),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .perm_start(perm_start), .perm_state_in(perm_state_in),
    .perm_state_out(perm_state_out), .perm_done(perm_done),
    .reseed_req(reseed_req), .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- permutation stand-in ----------------
  bit bfm_stuck = 0;
  bit bfm_const = 0;
  bit bfm_busy  = 0;
  int bfm_cnt   = 0;
  logic [319:0] bfm_lat = '0;

  function automatic logic [319:0] bfm_model(input logic [319:0] s, input bit cst);
    logic [319:0] r;
    r = {s[318:0], s[319]} ^ {5{64'h9E3779B97F4A7C15}};
    if (cst) r[319:256] = CONST_X0;
    return r;
  endfunction

  // Done drops the cycle after start and rises LAT cycles after start
  always @(posedge clk) begin
    if (perm_start && !bfm_stuck) begin
      bfm_lat   <= perm_state_in;
      bfm_cnt   <= 1;
      bfm_busy  <= 1'b1;
      perm_done <= 1'b0;
    end else if (bfm_busy) begin
      if (bfm_cnt == LAT - 1) begin
        perm_done      <= 1'b1;
        perm_state_out <= bfm_model(bfm_lat, bfm_const);
        bfm_busy       <= 1'b0;
      end else begin
        bfm_cnt <= bfm_cnt + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge of the cycle after the seed handshake
  task automatic drive_seed(input logic [127:0] d, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    seed_valid = 1'b1;
    seed_data  = d;
    while (!seed_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = seed_ready;
    @(negedge clk);
    seed_valid = 1'b0;
    seed_data  = '0;
  endtask

  // Counts negedges until rnd_valid, and start pulses seen on the way
  task automatic wait_word(output int cyc, output int starts, output bit ok);
    cyc = 0;
    starts = 0;
    ok = 0;
    while (cyc < 200) begin
      if (rnd_valid) begin
        ok = 1;
        break;
      end
      if (perm_start) starts++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    rnd_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({seed_ready, rnd_valid, perm_start, reseed_req, busy, error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000",
               {seed_ready, rnd_valid, perm_start, reseed_req, busy, error});
    end
    n_tests++;
    if (rnd_data !== 64'h0 || perm_state_in !== 320'h0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data: got rnd_data=%h state=%h fsm=%0d required zeros",
               rnd_data, perm_state_in, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (seed_ready !== 1'b1 || reseed_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: got seed_ready=%b reseed_req=%b required 1 0",
               seed_ready, reseed_req);
    end
  endtask

  task automatic test_first_word();
    bit ok;
    int cyc, starts;
    logic [127:0] s;
    s = 128'h0123456789ABCDEF0123456789ABCDEF;
    drive_seed(s, ok);
    exp_state = {IV, s, 128'h0};
    n_tests++;
    if (!ok || perm_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start: got ok=%b start=%b busy=%b required 1 1 1", ok, perm_start, busy);
    end
    n_tests++;
    if (perm_state_in !== exp_state) begin
      n_fail++;
      $display("FAIL first_absorb: got %h required %h", perm_state_in, exp_state);
    end
    wait_word(cyc, starts, ok);
    n_tests++;
    if (!ok || cyc != LAT + 1 || starts != 1) begin
      n_fail++;
      $display("FAIL first_latency: got ok=%b cyc=%0d starts=%0d required 1 %0d 1",
               ok, cyc, starts, LAT + 1);
    end
    exp_state = bfm_model(exp_state, 0);
    n_tests++;
    if (rnd_data !== exp_state[319:256]) begin
      n_fail++;
      $display("FAIL first_word: got %h required %h", rnd_data, exp_state[319:256]);
    end
  endtask

  task automatic test_backpressure();
    bit stable;
    stable = 1;
    seed_valid = 1'b1;
    seed_data  = {4{32'hF0F0F0F0}};
    for (int i = 0; i < 10; i++) begin
      if (rnd_valid !== 1'b1 || rnd_data !== exp_state[319:256] || seed_ready !== 1'b0)
        stable = 0;
      @(negedge clk);
    end
    seed_valid = 1'b0;
    seed_data  = '0;
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL hold_stable: got unstable word/valid or seed_ready=1 required stable %h",
               exp_state[319:256]);
    end
    consume();
    n_tests++;
    if (rnd_valid !== 1'b0 || perm_start !== 1'b1) begin
      n_fail++;
      $display("FAIL one_consume: got valid=%b start=%b required 0 1", rnd_valid, perm_start);
    end
    n_tests++;
    if (perm_state_in !== exp_state) begin
      n_fail++;
      $display("FAIL feedback_state: got %h required %h", perm_state_in, exp_state);
    end
  endtask

  task automatic test_reseed();
    bit ok;
    int cyc, starts, bad;
    logic [127:0] s;
    bad = 0;
    for (int w = 2; w <= RI; w++) begin
      wait_word(cyc, starts, ok);
      exp_state = bfm_model(exp_state, 0);
      if (!ok || cyc != LAT + 1 || rnd_data !== exp_state[319:256]) bad++;
      consume();
      if (w < RI && (perm_start !== 1'b1 || perm_state_in !== exp_state)) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL words_2_to_4: got %0d bad words required 0", bad);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (reseed_req !== 1'b1 || rnd_valid !== 1'b0 || seed_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL need_seed: got req=%b valid=%b ready=%b busy=%b required 1 0 1 0",
               reseed_req, rnd_valid, seed_ready, busy);
    end
    s = {128{1'b1}};
    drive_seed(s, ok);
    exp_state[255:128] = exp_state[255:128] ^ s;
    n_tests++;
    if (!ok || perm_start !== 1'b1 || perm_state_in !== exp_state) begin
      n_fail++;
      $display("FAIL reseed_absorb: got %h required %h", perm_state_in, exp_state);
    end
    wait_word(cyc, starts, ok);
    exp_state = bfm_model(exp_state, 0);
    n_tests++;
    if (!ok || rnd_data !== exp_state[319:256] || reseed_req !== 1'b0) begin
      n_fail++;
      $display("FAIL word5: got %h required %h", rnd_data, exp_state[319:256]);
    end
  endtask

  task automatic test_back_to_back();
    bit prev_v;
    int b2b, words, bad;
    prev_v = 0;
    b2b = 0;
    words = 0;
    bad = 0;
    rnd_ready = 1'b1;
    for (int c = 0; c < 200 && reseed_req !== 1'b1; c++) begin
      if (rnd_valid) begin
        if (prev_v) b2b++;
        if (words > 0) exp_state = bfm_model(exp_state, 0);
        if (rnd_data !== exp_state[319:256]) bad++;
        words++;
      end
      prev_v = rnd_valid;
      @(negedge clk);
    end
    rnd_ready = 1'b0;
    n_tests++;
    if (words != RI || b2b != 0 || bad != 0 || reseed_req !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got words=%0d b2b=%0d bad=%0d req=%b required %0d 0 0 1",
               words, b2b, bad, reseed_req, RI);
    end
  endtask

  task automatic test_timeout();
    bit ok, saw_valid, held;
    int first_err;
    first_err = 0;
    saw_valid = 0;
    held = 1;
    bfm_stuck = 1;
    drive_seed(128'h55AA55AA55AA55AA55AA55AA55AA55AA, ok);
    for (int c = 1; c <= TMO + 4; c++) begin
      @(negedge clk);
      if (error === 1'b1 && first_err == 0) first_err = c;
      if (rnd_valid) saw_valid = 1;
    end
    n_tests++;
    if (!ok || first_err != TMO + 1 || saw_valid) begin
      n_fail++;
      $display("FAIL timeout: got err_cycle=%0d saw_valid=%b required %0d 0",
               first_err, saw_valid, TMO + 1);
    end
    seed_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (error !== 1'b1 || seed_ready !== 1'b0 || perm_start !== 1'b0 || busy !== 1'b0)
        held = 0;
      @(negedge clk);
    end
    seed_valid = 1'b0;
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL err_sticky: got error cleared or handshake open required error held");
    end
    bfm_stuck = 0;
    apply_reset();
    n_tests++;
    if (error !== 1'b0 || seed_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cleared: got error=%b ready=%b required 0 1", error, seed_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int cyc, starts, bad;
    logic [127:0] s;
    bad = 0;
    drive_seed(128'h1111222233334444AAAABBBBCCCCDDDD, ok);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({seed_ready, rnd_valid, perm_start, reseed_req, busy, error} !== 6'b0 ||
        perm_state_in !== 320'h0) begin
      n_fail++;
      $display("FAIL reset_in_wait: got flags=%b state=%h required zeros",
               {seed_ready, rnd_valid, perm_start, reseed_req, busy, error}, perm_state_in);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rnd_valid || busy || perm_start || error) bad++;
    end
    n_tests++;
    if (bad != 0 || perm_done !== 1'b1 || perm_state_in !== 320'h0) begin
      n_fail++;
      $display("FAIL late_done: got %0d bad cycles done=%b required 0 1", bad, perm_done);
    end
    s = 128'hFEDCBA9876543210FEDCBA9876543210;
    drive_seed(s, ok);
    exp_state = {IV, s, 128'h0};
    n_tests++;
    if (!ok || perm_state_in !== exp_state) begin
      n_fail++;
      $display("FAIL restart_absorb: got %h required %h", perm_state_in, exp_state);
    end
    wait_word(cyc, starts, ok);
    exp_state = bfm_model(exp_state, 0);
    n_tests++;
    if (!ok || cyc != LAT + 1 || rnd_data !== exp_state[319:256]) begin
      n_fail++;
      $display("FAIL restart_word: got %h cyc=%0d required %h %0d",
               rnd_data, cyc, exp_state[319:256], LAT + 1);
    end
    consume();
  endtask

  task automatic test_repeat_word();
    bit ok;
    int cyc, starts;
    apply_reset();
    bfm_const = 1;
    drive_seed(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, ok);
    wait_word(cyc, starts, ok);
    n_tests++;
    if (!ok || rnd_data !== CONST_X0) begin
      n_fail++;
      $display("FAIL repeat_first: got %h required %h", rnd_data, CONST_X0);
    end
    consume();
`ifdef ASCON_RNG_HEALTH_EN
    begin
      bit saw_valid;
      int first_err;
      saw_valid = 0;
      first_err = 0;
      for (int c = 1; c <= LAT + 6; c++) begin
        @(negedge clk);
        if (rnd_valid) saw_valid = 1;
        if (error === 1'b1 && first_err == 0) first_err = c;
      end
      n_tests++;
      if (saw_valid || first_err != LAT + 1) begin
        n_fail++;
        $display("FAIL health_trip: got saw_valid=%b err_cycle=%0d required 0 %0d",
                 saw_valid, first_err, LAT + 1);
      end
    end
`else
    wait_word(cyc, starts, ok);
    n_tests++;
    if (!ok || rnd_data !== CONST_X0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_second: got %h error=%b required %h 0", rnd_data, error, CONST_X0);
    end
`endif
    bfm_const = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_word();
    test_backpressure();
    test_reseed();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_repeat_word();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
